// File: rtl/uart_receive.sv
// UART receiver: 8N1 (or 8E1 when UART_RX_PARITY_EN is defined), LSB first, WTIME clocks per bit.
// Samples each bit at mid-bit and reports a byte with a one-cycle valid pulse or an error pulse.
module uart_receive #(
  parameter int WTIME = 868
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       UART_RX,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CW = $clog2(WTIME);
  localparam logic [CW-1:0] HALF_M1 = CW'(WTIME / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(WTIME - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  logic          rx_meta;
  logic          rx_s;
  logic          rx_d;
  logic [1:0]    settle_reg;
  logic          armed_reg;
  state_t        state_reg;
  logic [CW-1:0] baud_reg;
  logic [2:0]    bit_reg;
  logic [7:0]    shift_reg;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_reg;
`endif

  // The synchronizer flops reset high, so edge detection stays disarmed until the
  // pipeline holds real line samples and the line has been seen high once.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_d       <= 1'b1;
      settle_reg <= 2'd0;
      armed_reg  <= 1'b0;
    end else begin
      rx_meta <= UART_RX;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
      if (settle_reg != 2'd2)
        settle_reg <= settle_reg + 2'd1;
      else if (rx_s)
        armed_reg <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_reg     <= 3'd0;
      shift_reg   <= 8'h00;
      data        <= 8'h00;
      valid       <= 1'b0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
      par_bad_reg <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (armed_reg && rx_d && !rx_s) begin
            state_reg <= START;
            baud_reg  <= '0;
            busy      <= 1'b1;
          end
        end
        START: begin
          if (baud_reg == HALF_M1) begin
            baud_reg <= '0;
            bit_reg  <= 3'd0;
            if (!rx_s) begin
              state_reg <= DATA;
            end else begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        DATA: begin
          if (baud_reg == FULL_M1) begin
            baud_reg  <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            bit_reg   <= bit_reg + 3'd1;
            if (bit_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_reg <= PARITY;
`else
              state_reg <= STOP;
`endif
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_reg == FULL_M1) begin
            baud_reg    <= '0;
            par_bad_reg <= rx_s ^ (^shift_reg);
            state_reg   <= STOP;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_reg == FULL_M1) begin
            baud_reg <= '0;
            if (!rx_s) begin
              // A low stop bit wins over any parity result and waits out a break.
              frame_err <= 1'b1;
              state_reg <= WAIT_HIGH;
            end else begin
              busy      <= 1'b0;
              state_reg <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bad_reg) begin
                parity_err <= 1'b1;
              end else begin
                data  <= shift_reg;
                valid <= 1'b1;
              end
`else
              data  <= shift_reg;
              valid <= 1'b1;
`endif
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receive.sv
// Self-checking bench for uart_receive: directed cases plus random frames against a
// frame-level model (expected pulse sequence, last good byte, fixed result latency).
`timescale 1ns/1ps
module tb_uart_receive;

  localparam int W = 10;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int NBITS = 10;
  localparam bit PAR = 1'b0;
`endif
  // Result pulse seen this many cycles after busy is first seen high.
  localparam int LAT = W / 2 + (NBITS - 1) * W;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       parity_err;

  uart_receive #(.WTIME(W)) dut (
    .CLOCK      (clk),
    .RESET      (rst),
    .UART_RX    (rx),
    .data       (data),
    .valid      (valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  typedef struct {
    int kind;  // 1 = valid, 2 = frame_err, 3 = parity_err
    int val;
    int cyc;
  } ev_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  logic [7:0] last_good = 8'h00;

  int   cyc = 0;
  int   rise_cyc = 0;
  int   fall_cyc = 0;
  logic prev_busy = 1'b0;
  logic prev_pulse = 1'b0;

  // Monitor: record result pulses and check their shape and timing.
  initial forever begin
    ev_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      if (busy && !prev_busy) rise_cyc = cyc;
      if (!busy && prev_busy) fall_cyc = cyc;
      if (valid || frame_err || parity_err) begin
        e.kind = valid ? 1 : (frame_err ? 2 : 3);
        e.val  = int'(data);
        e.cyc  = cyc;
        check("pulse_excl", int'(valid) + int'(frame_err) + int'(parity_err), 1);
        check("pulse_width", int'(prev_pulse), 0);
        check("pulse_latency", cyc - rise_cyc, LAT);
        check("busy_at_pulse", int'(busy), int'(frame_err));
        obs_q.push_back(e);
      end
    end
    prev_busy  = busy;
    prev_pulse = valid | frame_err | parity_err;
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int stop_low, input bit par_flip);
    hold(1'b0, W);
    for (int i = 0; i < 8; i++) hold(b[i], W);
    if (PAR) hold(logic'((^b) ^ par_flip), W);
    if (stop_low > 0) hold(1'b0, stop_low);
    hold(1'b1, W);
  endtask

  task automatic expect_frame(input logic [7:0] b, input int stop_low, input bit par_flip);
    ev_t e;
    e.val = int'(b);
    e.cyc = 0;
    if (stop_low > 0) e.kind = 2;
    else if (PAR && par_flip) e.kind = 3;
    else begin
      e.kind = 1;
      last_good = b;
    end
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    ev_t x;
    ev_t o;
    hold(1'b1, 2 * W);
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        check({tag, "_missing"}, 0, x.kind);
      end else begin
        o = obs_q.pop_front();
        check({tag, "_kind"}, o.kind, x.kind);
        if (x.kind == 1) check({tag, "_byte"}, o.val, x.val);
      end
    end
    check({tag, "_extra"}, obs_q.size(), 0);
    obs_q.delete();
    check({tag, "_data_reg"}, int'(data), int'(last_good));
  endtask

  initial begin
    logic [7:0] b;
    int         sl;
    bit         pf;
    int         gap;

    repeat (3) @(posedge clk);
    #1;
    check("rst_data", int'(data), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_parity_err", int'(parity_err), 0);
    @(negedge clk);
    rst = 1'b0;
    hold(1'b1, 5 * W);

    expect_frame(8'h67, 0, 1'b0);
    send(8'h67, 0, 1'b0);
    drain("f67");

    // Framing error: stop bit held low 30 cycles.
    expect_frame(8'h3C, 30, 1'b0);
    hold(1'b0, W);
    b = 8'h3C;
    for (int i = 0; i < 8; i++) hold(b[i], W);
    if (PAR) hold(logic'(^b), W);
    hold(1'b0, 30);
    check("ferr_busy_low", int'(busy), 1);
    hold(1'b1, W);
    check("ferr_busy_after", int'(busy), 0);
    drain("ferr");

    expect_frame(8'h01, 0, 1'b0);
    send(8'h01, 0, 1'b0);
    drain("f01");

    // Short glitch on the idle line.
    hold(1'b0, 3);
    hold(1'b1, 2 * W);
    check("glitch_busy_len", fall_cyc - rise_cyc, W / 2);
    drain("glitch");

    expect_frame(8'hA5, 0, 1'b0);
    send(8'hA5, 0, 1'b0);
    drain("fA5");

    // Back-to-back frames with a single stop bit.
    expect_frame(8'h00, 0, 1'b0);
    expect_frame(8'hFF, 0, 1'b0);
    send(8'h00, 0, 1'b0);
    send(8'hFF, 0, 1'b0);
    hold(1'b1, W);
    if (obs_q.size() >= 2) check("b2b_spacing", obs_q[1].cyc - obs_q[0].cyc, NBITS * W);
    else check("b2b_count", obs_q.size(), 2);
    drain("b2b");

    // Reset during bit 4 of 0xC1, released while the line is low.
    b = 8'hC1;
    hold(1'b0, W);
    for (int i = 0; i < 4; i++) hold(b[i], W);
    rx = b[4];
    repeat (W / 2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_data", int'(data), 0);
    check("mid_rst_valid", int'(valid), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    repeat (W - W / 2 - 2) @(negedge clk);
    for (int i = 5; i < 8; i++) hold(b[i], W);
    if (PAR) hold(logic'(^b), W);
    hold(1'b1, 3 * W);
    drain("midrst");

    expect_frame(8'h55, 0, 1'b0);
    send(8'h55, 0, 1'b0);
    drain("f55");

`ifdef UART_RX_PARITY_EN
    expect_frame(8'h67, 0, 1'b0);
    send(8'h67, 0, 1'b0);
    drain("par_ok");
    expect_frame(8'h67, 0, 1'b1);
    send(8'h67, 0, 1'b1);
    drain("par_bad");
`endif

    // Random frames with random gaps, framing and parity faults.
    for (int i = 0; i < 40; i++) begin
      b   = 8'($urandom_range(0, 255));
      sl  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(W, 3 * W)) : 0;
      pf  = PAR && ($urandom_range(0, 4) == 0);
      gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 3 * W));
      expect_frame(b, sl, pf);
      send(b, sl, pf);
      if (gap > 0) hold(1'b1, gap);
      if (i % 8 == 7) drain("rand");
    end
    drain("rand_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
